// File: rtl/optical_pkg.sv
// Shared definitions for the optical link: receive FSM state encoding and
// the default timing constants used by both transmitter and receiver.
//   RX_IDLE / RX_RUN / RX_HALF : receiver FSM states
//   *_DEF                      : default HALF_CYCLES / TOL / IDLE_CYCLES
//   within_tol()               : interval classification helper
package optical_pkg;

    localparam int HALF_CYCLES_DEF = 8;
    localparam int TOL_DEF         = 2;
    localparam int IDLE_CYCLES_DEF = 64;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_RUN  = 2'd1,
        RX_HALF = 2'd2
    } rx_state_e;

    // True when a measured length lies within +/-tol of the target length.
    function automatic logic within_tol(input int len, input int target, input int tol);
        return (len >= target - tol) && (len <= target + tol);
    endfunction

endpackage

// File: rtl/line_sync.sv
// Line synchroniser and edge detector for the asynchronous optical input.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   din      : raw line level, asynchronous to clk
//   level    : synchronised line level (second flop)
//   edge_det : high for one cycle when the synchronised level changed
module line_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic edge_det
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level    = s2;
    assign edge_det = s2 ^ s3;

endmodule

// File: rtl/bmc_receiver.sv
// Optical line receiver: decodes biphase-mark (or samples raw NRZ) into bits
// and assembles them LSB-first into bytes.
//   clk, rst   : system clock, synchronous active-high reset
//   din        : line level (asynchronous)
//   bmc_decode : 1 = biphase-mark decode, 0 = raw NRZ sampling
//   dout/vout  : recovered bit and its single-cycle strobe
//   byte_out   : last completed byte, byte_valid strobes when it updates
//   err        : single-cycle strobe on a line-code violation
//
// state   | meaning
// RX_IDLE | not synchronised, waiting for a lead-in edge
// RX_RUN  | at a bit-cell boundary
// RX_HALF | mid-cell transition seen, a second short interval completes a 1
module bmc_receiver
    import optical_pkg::*;
#(
    parameter int HALF_CYCLES = HALF_CYCLES_DEF,
    parameter int TOL         = TOL_DEF,
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       bmc_decode,
    output logic       dout,
    output logic       vout,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       err
);

    localparam int CW = $clog2(IDLE_CYCLES + 1);
    localparam int PW = $clog2(2 * HALF_CYCLES);

    logic          level;
    logic          edge_det;
    logic [CW-1:0] cnt;
    logic [PW-1:0] phase;
    rx_state_e     state;
    rx_state_e     st_next;
    logic          bmc_q;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    logic          timeout;
    logic          is_short;
    logic          is_long;
    logic          phase_mid;
    int            len;

    logic          emit;
    logic          emit_bit;
    logic          go_idle;
    logic          err_next;

    line_sync u_line_sync (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .level    (level),
        .edge_det (edge_det)
    );

    // Cycles since the last edge; saturation doubles as the BMC idle detector.
    always_ff @(posedge clk) begin
        if (rst || edge_det) begin
            cnt <= '0;
        end else if (cnt != CW'(IDLE_CYCLES)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Raw-mode bit phase, realigned on every line edge and held while idle.
    always_ff @(posedge clk) begin
        if (rst || edge_det || state == RX_IDLE) begin
            phase <= '0;
        end else if (phase == PW'(2 * HALF_CYCLES - 1)) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign len       = int'(cnt) + 1;
    assign is_short  = within_tol(len, HALF_CYCLES, TOL);
    assign is_long   = within_tol(len, 2 * HALF_CYCLES, TOL);
    assign timeout   = (cnt == CW'(IDLE_CYCLES));
    assign phase_mid = (phase == PW'(HALF_CYCLES - 1));

    always_comb begin
        st_next  = state;
        emit     = 1'b0;
        emit_bit = 1'b0;
        go_idle  = 1'b0;
        err_next = 1'b0;
        if (bmc_decode != bmc_q) begin
            // Mode switch: drop sync silently; priority over any decode this cycle.
            go_idle = 1'b1;
        end else if (bmc_decode) begin
            case (state)
                RX_IDLE: begin
                    if (edge_det) st_next = RX_RUN;
                end
                RX_RUN: begin
                    if (timeout) begin
                        go_idle = 1'b1;
                    end else if (edge_det) begin
                        if (is_long) begin
                            emit = 1'b1;
                        end else if (is_short) begin
                            st_next = RX_HALF;
                        end else begin
                            err_next = 1'b1;
                            go_idle  = 1'b1;
                        end
                    end
                end
                RX_HALF: begin
                    if (timeout) begin
                        err_next = 1'b1;
                        go_idle  = 1'b1;
                    end else if (edge_det) begin
                        if (is_short) begin
                            emit     = 1'b1;
                            emit_bit = 1'b1;
                            st_next  = RX_RUN;
                        end else begin
                            err_next = 1'b1;
                            go_idle  = 1'b1;
                        end
                    end
                end
                default: go_idle = 1'b1;
            endcase
        end else begin
            if (state == RX_IDLE) begin
                if (edge_det) st_next = RX_RUN;
            end else if (phase_mid) begin
                emit     = 1'b1;
                emit_bit = level;
            end
        end
        if (go_idle) st_next = RX_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            bmc_q      <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            dout       <= 1'b0;
            vout       <= 1'b0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= st_next;
            bmc_q      <= bmc_decode;
            vout       <= emit;
            err        <= err_next;
            byte_valid <= 1'b0;
            if (emit) dout <= emit_bit;
            if (go_idle) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (emit) begin
                // Right shift with the new bit at the MSB leaves the first bit at the LSB.
                shreg <= {emit_bit, shreg[7:1]};
                if (bit_cnt == 3'd7) begin
                    byte_out   <= {emit_bit, shreg[7:1]};
                    byte_valid <= 1'b1;
                    bit_cnt    <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bmc_receiver.sv
// Self-checking bench for bmc_receiver with HALF_CYCLES=8, TOL=2.
module tb_bmc_receiver;

    localparam int H    = 8;
    localparam int T    = 2;
    localparam int IDLE = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       bmc_decode;
    logic       dout;
    logic       vout;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       err;

    bmc_receiver #(.HALF_CYCLES(H), .TOL(T), .IDLE_CYCLES(IDLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .bmc_decode (bmc_decode),
        .dout       (dout),
        .vout       (vout),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_tog;

    bit         got_bits[$];
    int         vcyc[$];
    logic [7:0] got_bytes[$];
    int         got_errs;
    int         dbl;
    bit         prev_v, prev_bv, prev_e;

    int         ivq[$];
    bit         exp_bits[$];
    logic [7:0] exp_bytes[$];
    int         exp_errs;
    int         m_nb;
    logic [7:0] m_acc;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (vout) begin
            got_bits.push_back(dout);
            vcyc.push_back(cyc);
        end
        if (byte_valid) got_bytes.push_back(byte_out);
        if (err) got_errs++;
        if ((vout && prev_v) || (byte_valid && prev_bv) || (err && prev_e)) dbl++;
        prev_v  = vout;
        prev_bv = byte_valid;
        prev_e  = err;
    end

    function automatic void clear_mon();
        got_bits.delete();
        vcyc.delete();
        got_bytes.delete();
        got_errs = 0;
    endfunction

    function automatic logic [63:0] pack_bits(input bit q[$]);
        logic [63:0] r = '0;
        foreach (q[i]) if (i < 64) r[i] = q[i];
        return r;
    endfunction

    function automatic int jit_val(input bit en);
        if (!en) return 0;
        return int'($urandom_range(0, 2 * T)) - T;
    endfunction

    function automatic void enc_bit(input bit v, input bit jit);
        if (v) begin
            ivq.push_back(H + jit_val(jit));
            ivq.push_back(H + jit_val(jit));
        end else begin
            ivq.push_back(2 * H + jit_val(jit));
        end
    endfunction

    function automatic void enc_byte(input logic [7:0] b, input bit jit);
        for (int i = 0; i < 8; i++) enc_bit(b[i], jit);
    endfunction

    // Reference: one burst of edge intervals (first = lead-in) ending in silence.
    function automatic void model_add(input bit b);
        exp_bits.push_back(b);
        m_acc[m_nb] = b;
        m_nb++;
        if (m_nb == 8) begin
            exp_bytes.push_back(m_acc);
            m_nb = 0;
        end
    endfunction

    function automatic void model_burst();
        bit synced = 1'b0;
        bit half   = 1'b0;
        exp_bits.delete();
        exp_bytes.delete();
        exp_errs = 0;
        m_nb     = 0;
        m_acc    = '0;
        foreach (ivq[i]) begin
            int L;
            bit s;
            bit l;
            L = ivq[i];
            s = (L >= H - T) && (L <= H + T);
            l = (L >= 2 * H - T) && (L <= 2 * H + T);
            if (!synced) begin
                synced = 1'b1;
                half   = 1'b0;
                m_nb   = 0;
            end else if (!half) begin
                if (l) model_add(1'b0);
                else if (s) half = 1'b1;
                else begin
                    exp_errs++;
                    synced = 1'b0;
                end
            end else begin
                if (s) begin
                    half = 1'b0;
                    model_add(1'b1);
                end else begin
                    exp_errs++;
                    synced = 1'b0;
                    half   = 1'b0;
                end
            end
        end
        if (synced && half) exp_errs++;
    endfunction

    task automatic send_edges();
        foreach (ivq[i]) begin
            repeat (ivq[i]) @(negedge clk);
            din      = ~din;
            last_tog = cyc;
        end
    endtask

    task automatic send_burst();
        send_edges();
        repeat (IDLE + 30) @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        din        = 1'b0;
        bmc_decode = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({dout, vout, byte_out, byte_valid, err} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 000", {dout, vout, byte_out, byte_valid, err});
        end
        rst = 1'b0;
        clear_mon();
        repeat (80) @(negedge clk);
        n_tests++;
        if (got_bits.size() != 0 || got_errs != 0) begin
            n_fail++;
            $display("FAIL reset_quiet: got bits=%0d errs=%0d expected 0/0", got_bits.size(), got_errs);
        end
    endtask

    task automatic test_raw(input logic [7:0] b);
        int t0 = 0;
        int spacing_bad = 0;
        bmc_decode = 1'b0;
        repeat (4) @(negedge clk);
        clear_mon();
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            if (i == 0) t0 = cyc;
            repeat (16) @(negedge clk);
        end
        bmc_decode = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (got_bits.size() != 8 || pack_bits(got_bits) !== {56'h0, b}) begin
            n_fail++;
            $display("FAIL raw_bits: got n=%0d %h expected n=8 %h", got_bits.size(), pack_bits(got_bits), b);
        end
        n_tests++;
        if (got_bytes.size() != 1 || got_bytes[0] !== b) begin
            n_fail++;
            $display("FAIL raw_byte: got n=%0d first=%h expected n=1 %h", got_bytes.size(),
                     (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx, b);
        end
        for (int i = 1; i < vcyc.size(); i++) if (vcyc[i] - vcyc[i-1] != 16) spacing_bad++;
        n_tests++;
        if (spacing_bad != 0 || vcyc.size() == 0 || vcyc[0] - t0 < H || vcyc[0] - t0 > H + 3) begin
            n_fail++;
            $display("FAIL raw_timing: got bad_spacing=%0d first_offset=%0d expected 0 and %0d..%0d",
                     spacing_bad, (vcyc.size() > 0) ? vcyc[0] - t0 : -1, H, H + 3);
        end
        n_tests++;
        if (got_errs != 0) begin
            n_fail++;
            $display("FAIL raw_err: got %0d expected 0", got_errs);
        end
    endtask

    task automatic test_bmc_a5();
        clear_mon();
        ivq.delete();
        ivq.push_back(20);
        enc_byte(8'hA5, 1'b0);
        send_edges();
        repeat (6) @(negedge clk);
        n_tests++;
        if (vcyc.size() == 0 || vcyc[vcyc.size()-1] != last_tog + 3) begin
            n_fail++;
            $display("FAIL bmc_latency: got %0d expected %0d",
                     (vcyc.size() > 0) ? vcyc[vcyc.size()-1] : -1, last_tog + 3);
        end
        repeat (IDLE + 30) @(negedge clk);
        n_tests++;
        if (got_bits.size() != 8 || pack_bits(got_bits) !== 64'hA5) begin
            n_fail++;
            $display("FAIL a5_bits: got n=%0d %h expected n=8 a5", got_bits.size(), pack_bits(got_bits));
        end
        n_tests++;
        if (got_bytes.size() != 1 || got_bytes[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL a5_byte: got n=%0d expected one a5", got_bytes.size());
        end
        n_tests++;
        if (got_errs != 0) begin
            n_fail++;
            $display("FAIL a5_err: got %0d expected 0", got_errs);
        end
    endtask

    task automatic test_jitter();
        clear_mon();
        ivq = '{20, 6, 10, 18, 12, 8, 16, 8, 8};
        model_burst();
        send_burst();
        n_tests++;
        if (got_bits.size() != exp_bits.size() || pack_bits(got_bits) !== pack_bits(exp_bits)) begin
            n_fail++;
            $display("FAIL jitter_bits: got n=%0d %h expected n=%0d %h", got_bits.size(),
                     pack_bits(got_bits), exp_bits.size(), pack_bits(exp_bits));
        end
        n_tests++;
        if (got_errs != exp_errs || got_bytes.size() != 0) begin
            n_fail++;
            $display("FAIL jitter_err: got errs=%0d bytes=%0d expected %0d/0", got_errs,
                     got_bytes.size(), exp_errs);
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        ivq = '{20, 16, 8, 8, 8};
        send_burst();
        n_tests++;
        if (got_errs != 1 || got_bits.size() != 2) begin
            n_fail++;
            $display("FAIL timeout_err: got errs=%0d bits=%0d expected 1/2", got_errs, got_bits.size());
        end
        clear_mon();
        ivq.delete();
        ivq.push_back(20);
        enc_byte(8'h3C, 1'b1);
        send_burst();
        n_tests++;
        if (got_bytes.size() != 1 || got_bytes[0] !== 8'h3C || got_errs != 0) begin
            n_fail++;
            $display("FAIL timeout_3c: got n=%0d first=%h errs=%0d expected one 3c, 0 errs",
                     got_bytes.size(), (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx, got_errs);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        ivq.delete();
        ivq.push_back(20);
        for (int i = 0; i < 5; i++) enc_bit(1'($urandom_range(0, 1)), 1'b0);
        send_edges();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({dout, vout, byte_out, byte_valid, err} !== 12'h000) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h expected 000", {dout, vout, byte_out, byte_valid, err});
        end
        rst = 1'b0;
        repeat (IDLE + 40) @(negedge clk);
        ivq.delete();
        ivq.push_back(20);
        enc_byte(8'h81, 1'b1);
        send_burst();
        n_tests++;
        if (got_bytes.size() != 1 || got_bytes[0] !== 8'h81 || got_errs != 0 || got_bits.size() != 13) begin
            n_fail++;
            $display("FAIL rstmid_81: got bytes=%0d first=%h errs=%0d bits=%0d expected 1/81/0/13",
                     got_bytes.size(), (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx, got_errs,
                     got_bits.size());
        end
    endtask

    task automatic test_mode_toggle();
        logic [7:0] b;
        clear_mon();
        ivq.delete();
        ivq.push_back(20);
        for (int i = 0; i < 4; i++) enc_bit(1'($urandom_range(0, 1)), 1'b0);
        model_burst();
        send_edges();
        repeat (5) @(negedge clk);
        bmc_decode = 1'b0;
        repeat (20) @(negedge clk);
        n_tests++;
        if (got_bits.size() != 4 || pack_bits(got_bits) !== pack_bits(exp_bits) || got_errs != 0) begin
            n_fail++;
            $display("FAIL toggle_quiet: got n=%0d %h errs=%0d expected n=4 %h errs=0", got_bits.size(),
                     pack_bits(got_bits), got_errs, pack_bits(exp_bits));
        end
        b    = 8'($urandom_range(0, 255));
        b[0] = ~din;
        test_raw(b);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int nbytes;
            int mism;
            nbytes = int'($urandom_range(1, 2));
            clear_mon();
            ivq.delete();
            ivq.push_back(20);
            for (int k = 0; k < nbytes; k++) enc_byte(8'($urandom_range(0, 255)), 1'b1);
            for (int i = 1; i < ivq.size(); i++)
                if ($urandom_range(0, 7) == 0) ivq[i] = int'($urandom_range(3, 30));
            model_burst();
            send_burst();
            n_tests++;
            if (got_bits.size() != exp_bits.size() || pack_bits(got_bits) !== pack_bits(exp_bits)) begin
                n_fail++;
                $display("FAIL rand_bits[%0d]: got n=%0d %h expected n=%0d %h", it, got_bits.size(),
                         pack_bits(got_bits), exp_bits.size(), pack_bits(exp_bits));
            end
            mism = 0;
            if (got_bytes.size() != exp_bytes.size()) mism = 1;
            else foreach (exp_bytes[i]) if (got_bytes[i] !== exp_bytes[i]) mism++;
            n_tests++;
            if (mism != 0 || got_errs != exp_errs) begin
                n_fail++;
                $display("FAIL rand_bytes[%0d]: got bytes=%0d errs=%0d expected bytes=%0d errs=%0d",
                         it, got_bytes.size(), got_errs, exp_bytes.size(), exp_errs);
            end
        end
        n_tests++;
        if (dbl != 0) begin
            n_fail++;
            $display("FAIL strobe_width: got %0d multi-cycle strobes expected 0", dbl);
        end
    endtask

    initial begin
        dbl     = 0;
        prev_v  = 1'b0;
        prev_bv = 1'b0;
        prev_e  = 1'b0;
        test_reset();
        test_raw(8'h0F);
        test_bmc_a5();
        test_jitter();
        test_timeout();
        test_reset_mid();
        test_mode_toggle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bmc_receiver.md
BMC_RECEIVER -- requirements
Module: bmc_receiver

Interface
REQ-001 Parameter HALF_CYCLES, default 8, clk cycles per half bit (line bit period = 2*HALF_CYCLES).
REQ-002 Parameter TOL, default 2, allowed +/- cycles on measured intervals; SHALL satisfy TOL < HALF_CYCLES/2.
REQ-003 Parameter IDLE_CYCLES, default 64, edge-free cycles before BMC link declared idle; SHALL exceed 2*HALF_CYCLES+TOL.
REQ-004 clk  input  1  system clock, all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 din  input  1  optical line level, asynchronous to clk.
REQ-007 bmc_decode  input  1  1 = biphase-mark line code, 0 = raw NRZ.
REQ-008 dout  output  1  recovered bit, valid only with vout.
REQ-009 vout  output  1  single-cycle strobe per recovered bit.
REQ-010 byte_out  output  8  assembled byte, LSB = first received bit.
REQ-011 byte_valid  output  1  single-cycle strobe, byte_out valid.
REQ-012 err  output  1  single-cycle strobe on line-code violation.

Function
REQ-013 din SHALL pass a 2-flop synchroniser, then a third flop; an edge is a mismatch between stages 2 and 3.
REQ-014 Interval counter SHALL clear to 0 on an edge cycle, else increment, saturating at IDLE_CYCLES; measured length L = count+1 at each edge.
REQ-015 Classification: short if |L-HALF_CYCLES| <= TOL, long if |L-2*HALF_CYCLES| <= TOL, otherwise invalid.
REQ-016 FSM states IDLE, RUN, HALF; from IDLE the first edge SHALL enter RUN with no bit emitted.
REQ-017 BMC, RUN: long -> emit 0, stay RUN; short -> HALF; invalid -> err, IDLE.
REQ-018 BMC, HALF: short -> emit 1, RUN; long or invalid -> err, IDLE.
REQ-019 BMC: counter reaching IDLE_CYCLES SHALL force IDLE; err SHALL pulse only if the state was HALF.
REQ-020 Raw mode: phase counter SHALL reset to 0 on each edge and on IDLE exit, wrap at 2*HALF_CYCLES-1; when phase = HALF_CYCLES-1, emit stage-2 level as the bit. No timeout in raw mode; err never asserted.
REQ-021 vout/dout SHALL be registered; a BMC bit strobes on the 2nd rising clk edge after the edge that first captures the completing din transition.
REQ-022 Each emitted bit SHALL shift into byte register LSB-first; after the 8th bit, byte_out updates and byte_valid pulses in the same cycle as that bit's vout; bit count returns to 0.
REQ-023 Entering IDLE (timeout, error, mode change) SHALL clear the bit count and discard the partial byte; byte_out holds its last value.
REQ-024 A change of bmc_decode SHALL force IDLE the next cycle, no err, no bit emitted.
REQ-025 vout, byte_valid and err SHALL never be asserted for more than one consecutive cycle per event.

Reset
REQ-026 On rst: state IDLE; all sync flops, counters, bit count, byte register 0; dout, vout, byte_out, byte_valid, err all 0.
REQ-027 rst mid-byte or mid-HALF SHALL discard partial data with no err pulse; reception restarts from the next edge.

Structure
REQ-028 Shared package optical_pkg SHALL hold the rx FSM state enum and default HALF_CYCLES/TOL/IDLE_CYCLES constants shared with the transmitter.
REQ-029 One sub-module line_sync SHALL implement the synchroniser and edge detector (outputs: level, edge).

Verification (HALF_CYCLES=8, TOL=2)
REQ-030 BMC byte 0xA5 (LSB first 1,0,1,0,0,1,0,1) after one lead-in edge -> 8 vout strobes with those bits, byte_valid with byte_out=0xA5, err never.
REQ-031 Jitter: intervals 6,10 for a 1 and 18 for a 0 -> bits 1,0 decoded; interval 12 -> err pulse, next bit requires a fresh lead-in edge.
REQ-032 Short followed by no edge for 64 cycles -> err pulse, IDLE, partial byte discarded; subsequent 0x3C received correctly.
REQ-033 Raw mode, NRZ 16-cycle bits of 0x0F -> byte_valid, byte_out=0x0F, one sample per 16 cycles at mid-bit.
REQ-034 rst asserted after 5 bits of a byte -> all outputs 0 next cycle, no err; following full byte 0x81 decoded correctly.
REQ-035 Toggle bmc_decode mid-byte -> no vout/err, bit count cleared; next byte in new mode decoded.
